// File: rtl/unidade_controle_if.sv
// Memory handshake between the control unit (master) and the memory (slave).
interface unidade_controle_if;
  localparam int unsigned DW = 8;

  logic [DW-1:0] memdado;
  logic          mempronto;
  logic [DW-1:0] memend;
  logic          memle;
  logic          memescreve;

  modport master (
    input  memdado, mempronto,
    output memend, memle, memescreve
  );

  modport slave (
    output memdado, mempronto,
    input  memend, memle, memescreve
  );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: owns PC/IR, fetches 1- and 2-byte instructions and
// sequences them into the write-back mux and register file.
module unidade_controle (
  input  logic                      clk,
  input  logic                      rst_n,
  unidade_controle_if.master        mem,
  input  logic [7:0]                enddados,
  input  logic                      zero,
  output logic [7:0]                pc,
  output logic [2:0]                opcode,
  output logic                      selsaida,
  output logic [7:0]                imediato,
  output logic [1:0]                rega,
  output logic [1:0]                regb,
  output logic                      escrevereg,
  output logic                      parado
);
  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_ADD  = 3'b000;
  localparam logic [OPW-1:0] OP_SUB  = 3'b001;
  localparam logic [OPW-1:0] OP_LI   = 3'b010;
  localparam logic [OPW-1:0] OP_LD   = 3'b011;
  localparam logic [OPW-1:0] OP_ST   = 3'b100;
  localparam logic [OPW-1:0] OP_BEQ  = 3'b101;
  localparam logic [OPW-1:0] OP_JMP  = 3'b110;
  localparam logic [OPW-1:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    INICIO, BUSCA, DECODIFICA, BUSCA_IMM, EXECUTA, MEMORIA, ESCRITA, PARADO
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   ir, ir_n;
  logic [DW-1:0]   pc_n, imm_n;
  logic [OPW-1:0]  op, op_n;
  logic            memle_n, memesc_n, escreve_n, sel_n, parado_n;
  logic [DW-1:0]   memend_n;

  assign op     = ir[7:5];
  assign op_n   = ir_n[7:5];
  assign opcode = ir[7:5];
  assign rega   = ir[4:3];
  assign regb   = ir[2:1];

  // Next state and architectural registers; PC/IR/Imediato move only on a completed read.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    imm_n   = imediato;
    unique case (state)
      INICIO: state_n = BUSCA;
      BUSCA: begin
        if (mem.mempronto) begin
          ir_n    = mem.memdado;
          pc_n    = pc + 8'd1;
          state_n = DECODIFICA;
        end
      end
      DECODIFICA: begin
        case (op)
          OP_ADD, OP_SUB:         state_n = EXECUTA;
          OP_LD, OP_ST:           state_n = MEMORIA;
          OP_LI, OP_BEQ, OP_JMP:  state_n = BUSCA_IMM;
          OP_HALT:                state_n = PARADO;
        endcase
      end
      BUSCA_IMM: begin
        if (mem.mempronto) begin
          imm_n = mem.memdado;
          pc_n  = pc + 8'd1;
          if (op == OP_JMP || (op == OP_BEQ && zero)) pc_n = mem.memdado;
          state_n = (op == OP_LI) ? ESCRITA : BUSCA;
        end
      end
      EXECUTA: state_n = ESCRITA;
      MEMORIA: begin
        if (mem.mempronto) state_n = (op == OP_LD) ? ESCRITA : BUSCA;
      end
      ESCRITA: state_n = BUSCA;
      PARADO:  state_n = PARADO;
      default: state_n = INICIO;
    endcase
  end

  // Outputs decoded from the upcoming state and IR, then registered with it.
  always_comb begin
    memle_n   = 1'b0;
    memesc_n  = 1'b0;
    memend_n  = '0;
    escreve_n = 1'b0;
    sel_n     = 1'b0;
    parado_n  = 1'b0;
    unique case (state_n)
      BUSCA, BUSCA_IMM: begin
        memle_n  = 1'b1;
        memend_n = pc_n;
      end
      MEMORIA: begin
        memend_n = enddados;
        memle_n  = (op_n == OP_LD);
        memesc_n = (op_n == OP_ST);
      end
      ESCRITA: begin
        escreve_n = 1'b1;
        sel_n     = (op_n == OP_ADD) || (op_n == OP_SUB);
      end
      PARADO:  parado_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= INICIO;
      pc             <= '0;
      ir             <= '0;
      imediato       <= '0;
      mem.memle      <= 1'b0;
      mem.memescreve <= 1'b0;
      mem.memend     <= '0;
      escrevereg     <= 1'b0;
      selsaida       <= 1'b0;
      parado         <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      ir             <= ir_n;
      imediato       <= imm_n;
      mem.memle      <= memle_n;
      mem.memescreve <= memesc_n;
      mem.memend     <= memend_n;
      escrevereg     <= escreve_n;
      selsaida       <= sel_n;
      parado         <= parado_n;
    end
  end
endmodule

// File: tb/tb_unidade_controle.sv
// Table of single-instruction programs checked through a scoreboard of memory
// accesses and register writes, plus reset and HALT sequences.
module tb_unidade_controle;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] enddados;
  logic       zero;
  logic [7:0] pc, imediato;
  logic [2:0] opcode;
  logic [1:0] rega, regb;
  logic       selsaida, escrevereg, parado;

  unidade_controle_if bus ();
  logic [7:0] mem [256];
  assign bus.memdado = mem[bus.memend];

  unidade_controle dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .enddados(enddados), .zero(zero),
    .pc(pc), .opcode(opcode), .selsaida(selsaida), .imediato(imediato),
    .rega(rega), .regb(regb), .escrevereg(escrevereg), .parado(parado)
  );

  typedef struct packed {
    logic [1:0] kind;   // 1 read, 2 write, 3 register write
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0]    at;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic          z;
    logic [7:0]    dados;
    int            stall;
    int            ncyc;
    logic [7:0]    pc_exp;
    int            nev;
    ev_t [2:0]     evs;
  } vec_t;

  int   total = 0, passed = 0;
  int   stall = 0, wcnt = 0, both_cnt = 0;
  logic mon_en = 1'b0, rand_idle = 1'b0;
  ev_t  sbq [$];
  vec_t vt [11];

  function automatic ev_t rd(input logic [7:0] ad);
    return '{kind: 2'd1, a: ad, b: 8'h00};
  endfunction
  function automatic ev_t wr(input logic [7:0] ad);
    return '{kind: 2'd2, a: ad, b: 8'h00};
  endfunction
  function automatic ev_t rw(input logic [1:0] ra, input logic sel, input logic [2:0] op,
                             input logic [7:0] imm);
    return '{kind: 2'd3, a: {ra, sel, op, 2'b00}, b: imm};
  endfunction

  function automatic vec_t mk(input logic [7:0] at, input logic [7:0] b0, input logic [7:0] b1,
                              input logic z, input logic [7:0] dados, input int st,
                              input int nc, input logic [7:0] pcx, input int ne,
                              input ev_t e0, input ev_t e1, input ev_t e2);
    vec_t v;
    v.at = at; v.b0 = b0; v.b1 = b1; v.z = z; v.dados = dados;
    v.stall = st; v.ncyc = nc; v.pc_exp = pcx; v.nev = ne;
    v.evs[0] = e0; v.evs[1] = e1; v.evs[2] = e2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic sb_pop(input ev_t act, input string nm);
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: unexpected event %h with nothing expected", nm, act);
    end else begin
      check(nm, 64'(act), 64'(sbq.pop_front()));
    end
  endtask

  // One clock: sample after the edge, drive the memory ready for this cycle, log events.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus.memle && bus.memescreve) both_cnt++;
    if (bus.memle || bus.memescreve) begin
      if (wcnt < stall) begin
        bus.mempronto = 1'b0;
        wcnt++;
      end else begin
        bus.mempronto = 1'b1;
        wcnt = 0;
      end
    end else begin
      bus.mempronto = rand_idle ? 1'($urandom_range(0, 1)) : 1'b0;
      wcnt = 0;
    end
    if (mon_en) begin
      if ((bus.memle || bus.memescreve) && bus.mempronto)
        sb_pop(bus.memle ? rd(bus.memend) : wr(bus.memend), "mem_access");
      if (escrevereg) sb_pop(rw(rega, selsaida, opcode, imediato), "reg_write");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.mempronto = 1'b0;
    wcnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // A nonzero start address is reached through a JMP at 00.
  task automatic run_vec(input vec_t v, input int idx);
    clear_mem();
    mem[8'h00] = 8'hC0;
    if (v.at != 8'h00) mem[8'h01] = v.at;
    mem[v.at] = v.b0;
    mem[8'(v.at + 8'd1)] = v.b1;
    zero = v.z; enddados = v.dados;
    stall = 0; mon_en = 1'b0; rand_idle = 1'b0;
    do_reset();
    if (v.at != 8'h00) repeat (3) cyc();
    stall = v.stall;
    sbq.delete();
    for (int i = 0; i < v.nev; i++) sbq.push_back(v.evs[i]);
    mon_en = 1'b1;
    repeat (v.ncyc) cyc();
    check($sformatf("v%0d_not_early", idx),
          64'(bus.memle && bus.memend == v.pc_exp && pc == v.pc_exp), 64'd0);
    mon_en = 1'b0;
    check($sformatf("v%0d_sb_drained", idx), 64'(sbq.size()), 64'd0);
    cyc();
    check($sformatf("v%0d_next_fetch", idx), {pc, bus.memle, bus.memend},
          {v.pc_exp, 1'b1, v.pc_exp});
  endtask

  initial begin
    rst_n = 1'b0; zero = 1'b0; enddados = 8'h00; bus.mempronto = 1'b0;
    vt[0]  = mk(8'h00, 8'h0C, 8'h00, 1'b0, 8'h00, 0, 4, 8'h01, 2,
                rd(8'h00), rw(2'b01, 1'b1, 3'b000, 8'h00), '0);
    vt[1]  = mk(8'h00, 8'h38, 8'h00, 1'b0, 8'h00, 1, 5, 8'h01, 2,
                rd(8'h00), rw(2'b11, 1'b1, 3'b001, 8'h00), '0);
    vt[2]  = mk(8'h00, 8'h48, 8'h5A, 1'b0, 8'h00, 2, 8, 8'h02, 3,
                rd(8'h00), rd(8'h01), rw(2'b01, 1'b0, 3'b010, 8'h5A));
    vt[3]  = mk(8'h00, 8'h50, 8'hA5, 1'b0, 8'h00, 0, 4, 8'h02, 3,
                rd(8'h00), rd(8'h01), rw(2'b10, 1'b0, 3'b010, 8'hA5));
    vt[4]  = mk(8'h00, 8'h72, 8'h00, 1'b0, 8'h80, 0, 4, 8'h01, 3,
                rd(8'h00), rd(8'h80), rw(2'b10, 1'b0, 3'b011, 8'h00));
    vt[5]  = mk(8'h00, 8'h82, 8'h00, 1'b0, 8'h80, 2, 7, 8'h01, 2,
                rd(8'h00), wr(8'h80), '0);
    vt[6]  = mk(8'h10, 8'hA0, 8'h40, 1'b1, 8'h00, 0, 3, 8'h40, 2, rd(8'h10), rd(8'h11), '0);
    vt[7]  = mk(8'h10, 8'hA0, 8'h40, 1'b0, 8'h00, 0, 3, 8'h12, 2, rd(8'h10), rd(8'h11), '0);
    vt[8]  = mk(8'hFE, 8'hC0, 8'h07, 1'b0, 8'h00, 0, 3, 8'h07, 2, rd(8'hFE), rd(8'hFF), '0);
    vt[9]  = mk(8'hFF, 8'h0C, 8'hC0, 1'b0, 8'h00, 0, 4, 8'h00, 2,
                rd(8'hFF), rw(2'b01, 1'b1, 3'b000, 8'hFF), '0);
    vt[10] = mk(8'h10, 8'hA0, 8'h40, 1'b1, 8'h00, 1, 5, 8'h40, 2, rd(8'h10), rd(8'h11), '0);

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Reset while a store is waiting in MEMORIA.
    clear_mem();
    mem[8'h00] = 8'h82; enddados = 8'h80; stall = 0; mon_en = 1'b0;
    do_reset();
    cyc(); cyc();
    stall = 5;
    cyc();
    check("st_pending", {bus.memescreve, bus.memle, bus.memend}, {1'b1, 1'b0, 8'h80});
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {bus.memle, bus.memescreve, bus.memend, pc, opcode, selsaida, imediato,
              rega, regb, escrevereg, parado}, 64'd0);
    bus.mempronto = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mempronto = 1'b0;
    check("inicio_idle", {bus.memle, bus.memescreve, pc}, 64'd0);
    stall = 0;
    cyc();
    check("first_fetch", {bus.memle, bus.memend}, {1'b1, 8'h00});

    // HALT parks the unit whatever the memory ready does.
    clear_mem();
    mem[8'h00] = 8'hE0; stall = 0; rand_idle = 1'b1;
    do_reset();
    cyc(); cyc();
    check("halt_c2", 64'(parado), 64'd0);
    cyc();
    check("halt_c3", 64'(parado), 64'd1);
    begin
      int viol = 0;
      repeat (20) begin
        cyc();
        if (bus.memle || bus.memescreve || !parado) viol++;
      end
      check("halt_quiet", 64'(viol), 64'd0);
    end
    check("halt_pc", 64'(pc), 64'h01);
    rst_n = 1'b0;
    #1 check("halt_reset", 64'(parado), 64'd0);
    rand_idle = 1'b0;
    check("never_both_req", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
